// File: rtl/ysyx_22040000_key_lut_pipe.sv
// Run-time programmable key->data lookup table; a lookup is answered one cycle later over a valid/ready handshake.
// Optional multi-hit reporting on rsp_multi is built only when YSYX_22040000_MULTIHIT_CHK_EN is defined.
module ysyx_22040000_key_lut_pipe #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int PRIORITY    = 1,
  parameter int IDX_W       = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_hit,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic                rsp_multi
);

  logic [NR_KEY-1:0]   r_valid;
  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];

  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic [IDX_W-1:0]    r_rsp_idx;

  logic                w_idx_ok;
  logic                w_accept;
  logic [NR_KEY-1:0]   w_match;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_LEN-1:0] w_pri_data;
  logic [DATA_LEN-1:0] w_or_data;
  logic [DATA_LEN-1:0] w_rsp_data;

  // Non-power-of-2 depths leave some wr_idx codes with no backing entry
  assign w_idx_ok  = int'(wr_idx) < NR_KEY;
  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_idx_ok) begin
      if (wr_en) r_valid[wr_idx] <= 1'b1;
      else if (inv_en) r_valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush && w_idx_ok) begin
      r_key[wr_idx]  <= wr_key;
      r_data[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      w_match[i] = r_valid[i] && (r_key[i] == req_key);
    end
  end

  // Ascending scan: the first match seen fixes idx and priority data
  always_comb begin
    w_hit      = 1'b0;
    w_idx      = '0;
    w_pri_data = '0;
    w_or_data  = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_match[i]) begin
        if (!w_hit) begin
          w_idx      = IDX_W'(i);
          w_pri_data = r_data[i];
        end
        w_hit     = 1'b1;
        w_or_data = w_or_data | r_data[i];
      end
    end
  end

  always_comb begin
    if (w_hit) w_rsp_data = (PRIORITY != 0) ? w_pri_data : w_or_data;
    else       w_rsp_data = (HAS_DEFAULT != 0) ? default_out : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_idx   <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= w_hit;
      r_rsp_data  <= w_rsp_data;
      r_rsp_idx   <= w_idx;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_data  = r_rsp_data;
  assign rsp_idx   = r_rsp_idx;

`ifdef YSYX_22040000_MULTIHIT_CHK_EN
  logic w_multi;
  logic w_seen;
  logic r_multi;

  always_comb begin
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_match[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // Sticky: once any accepted lookup multi-hits, the flag stays up until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_multi <= 1'b0;
    else if (w_accept && w_multi) r_multi <= 1'b1;
  end

  assign rsp_multi = r_multi;
`else
  assign rsp_multi = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040000_key_lut_pipe.sv
// Directed bench for ysyx_22040000_key_lut_pipe: a priority/default instance and an OR/no-default instance share stimulus.
module tb_ysyx_22040000_key_lut_pipe;

  localparam int NR_KEY = 4;
  localparam int KEY_LEN = 8;
  localparam int DATA_LEN = 32;
  localparam int IDX_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en, inv_en, flush;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic [DATA_LEN-1:0] default_out;
  logic                req_valid;
  logic [KEY_LEN-1:0]  req_key;
  logic                rsp_ready;

  logic                req_ready, rsp_valid, rsp_hit, rsp_multi;
  logic [DATA_LEN-1:0] rsp_data;
  logic [IDX_W-1:0]    rsp_idx;

  logic                req_ready0, rsp_valid0, rsp_hit0, rsp_multi0;
  logic [DATA_LEN-1:0] rsp_data0;
  logic [IDX_W-1:0]    rsp_idx0;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_multi_on;

  always #5 clk = ~clk;

  ysyx_22040000_key_lut_pipe #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
    .HAS_DEFAULT(1), .PRIORITY(1), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .inv_en(inv_en), .flush(flush), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .rsp_idx(rsp_idx), .rsp_multi(rsp_multi)
  );

  ysyx_22040000_key_lut_pipe #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
    .HAS_DEFAULT(0), .PRIORITY(0), .IDX_W(IDX_W)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .inv_en(inv_en), .flush(flush), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready0), .req_key(req_key),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit0),
    .rsp_data(rsp_data0), .rsp_idx(rsp_idx0), .rsp_multi(rsp_multi0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic v, input logic h,
                     input logic [31:0] d, input logic [1:0] i);
    check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    check({tag, ".hit"},   64'(rsp_hit),   64'(h));
    check({tag, ".data"},  64'(rsp_data),  64'(d));
    check({tag, ".idx"},   64'(rsp_idx),   64'(i));
  endtask

  initial begin
`ifdef YSYX_22040000_MULTIHIT_CHK_EN
    exp_multi_on = 1'b1;
`else
    exp_multi_on = 1'b0;
`endif
    rst_n = 1'b0; wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0;
    wr_idx = '0; wr_key = '0; wr_data = '0; default_out = 32'hDEAD;
    req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
    tick(); tick();
    rsp("reset", 1'b0, 1'b0, 32'h0, 2'd0);
    check("reset.multi", 64'(rsp_multi), 64'd0);
    check("reset.req_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // 1: miss on empty table
    req_valid = 1'b1; req_key = 8'h00;
    tick();
    rsp("t1_miss", 1'b1, 1'b0, 32'hDEAD, 2'd0);
    check("t1_miss_nodef.data", 64'(rsp_data0), 64'd0);
    req_valid = 1'b0;
    tick();
    check("t1_drain.valid", 64'(rsp_valid), 64'd0);

    // 2: single write then hit
    wr_en = 1'b1; wr_idx = 2'd2; wr_key = 8'h5A; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0; req_valid = 1'b1; req_key = 8'h5A;
    tick();
    rsp("t2_hit", 1'b1, 1'b1, 32'h1234, 2'd2);
    req_valid = 1'b0;
    tick();

    // 3: duplicate key in idx1 and idx3
    wr_en = 1'b1; wr_idx = 2'd1; wr_key = 8'h11; wr_data = 32'h0F0;
    tick();
    wr_idx = 2'd3; wr_data = 32'hF00;
    tick();
    wr_en = 1'b0; req_valid = 1'b1; req_key = 8'h11;
    tick();
    rsp("t3_pri", 1'b1, 1'b1, 32'h0F0, 2'd1);
    check("t3_or.data", 64'(rsp_data0), 64'hFF0);
    check("t3_or.idx", 64'(rsp_idx0), 64'd1);
    check("t3.multi", 64'(rsp_multi), 64'(exp_multi_on));
    req_valid = 1'b0;
    tick();

    // 4: stall for 3 cycles with a second request waiting
    rsp_ready = 1'b0; req_valid = 1'b1; req_key = 8'h5A;
    tick();
    rsp("t4_first", 1'b1, 1'b1, 32'h1234, 2'd2);
    req_key = 8'h11;
    for (int c = 0; c < 3; c++) begin
      check("t4_stall.req_ready", 64'(req_ready), 64'd0);
      rsp("t4_hold", 1'b1, 1'b1, 32'h1234, 2'd2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_release.req_ready", 64'(req_ready), 64'd1);
    tick();
    rsp("t4_second", 1'b1, 1'b1, 32'h0F0, 2'd1);
    req_valid = 1'b0;
    tick();
    check("t4_nodup.valid", 64'(rsp_valid), 64'd0);

    // 5: read-before-invalidate, then miss, then flush beats write
    req_valid = 1'b1; req_key = 8'h5A; inv_en = 1'b1; wr_idx = 2'd2;
    tick();
    rsp("t5_old", 1'b1, 1'b1, 32'h1234, 2'd2);
    inv_en = 1'b0;
    tick();
    rsp("t5_inv_miss", 1'b1, 1'b0, 32'hDEAD, 2'd0);
    req_valid = 1'b0;
    flush = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 8'h77; wr_data = 32'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    req_valid = 1'b1; req_key = 8'h11;
    tick();
    rsp("t5_flush_11", 1'b1, 1'b0, 32'hDEAD, 2'd0);
    req_key = 8'h77;
    tick();
    rsp("t5_flush_77", 1'b1, 1'b0, 32'hDEAD, 2'd0);
    req_valid = 1'b0;
    wr_en = 1'b1; inv_en = 1'b1; wr_idx = 2'd0; wr_key = 8'h22; wr_data = 32'h22;
    tick();
    wr_en = 1'b0; inv_en = 1'b0; req_valid = 1'b1; req_key = 8'h22;
    tick();
    rsp("t5_wr_over_inv", 1'b1, 1'b1, 32'h22, 2'd0);
    req_valid = 1'b0;

    // 6: asynchronous reset with a pending response
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    rsp("t6_async", 1'b0, 1'b0, 32'h0, 2'd0);
    check("t6_async.multi", 64'(rsp_multi), 64'd0);
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b1; req_key = 8'h22;
    tick();
    rsp("t6_empty", 1'b1, 1'b0, 32'hDEAD, 2'd0);
    req_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
